mem_bus_fabric: RTL

- Parametrised successor to the fixed four-way SoC address decode.
- Connects the single core memory port (valid/ready, 32-bit) to NUM_SLAVES slave ports through a base/last address map set by parameters.
- Registers each transaction and steers it to exactly one slave.
- Returns an error response for unmapped addresses and, optionally, for hung slaves.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_bus_decode.sv | 26 ++
 rtl/mem_bus_fabric.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared state encoding and constants for the memory bus fabric and its decoder.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } bus_state_e;

   localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

   // Width of a binary slave index; never below one bit so NUM_SLAVES = 1 still works.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational base/last address decoder: one-hot slave select, lowest index wins on overlap.
module mem_bus_decode
   import mem_bus_pkg::*;
#(
   parameter int                        NUM_SLAVES = 4,
   parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE = {32'h0300_0000, 32'h0200_0000, 32'h0000_1000, 32'h0000_0000},
   parameter logic [32*NUM_SLAVES-1:0]  SLAVE_LAST = {32'hFFFF_FFFF, 32'h0200_0003, 32'h01FF_FFFF, 32'h0000_0FFF}
) (
   input  logic [31:0]           addr,
   output logic [NUM_SLAVES-1:0] sel,
   output logic                  miss
);

   logic [NUM_SLAVES-1:0] hit_s;

   // Range compare per slave, then isolate the lowest set bit for priority.
   always_comb begin
      hit_s = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         hit_s[i] = (addr >= SLAVE_BASE[32*i +: 32]) && (addr <= SLAVE_LAST[32*i +: 32]);
      end
      sel  = hit_s & (~hit_s + NUM_SLAVES'(1));
      miss = ~|hit_s;
   end

endmodule

// File: rtl/mem_bus_fabric.sv
// Single-master to NUM_SLAVES memory fabric with registered request/response path.
// Optional hung-slave timeout is enabled by defining BUS_TIMEOUT_EN.
module mem_bus_fabric
   import mem_bus_pkg::*;
#(
   parameter int                        NUM_SLAVES     = 4,
   parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {32'h0300_0000, 32'h0200_0000, 32'h0000_1000, 32'h0000_0000},
   parameter logic [32*NUM_SLAVES-1:0]  SLAVE_LAST     = {32'hFFFF_FFFF, 32'h0200_0003, 32'h01FF_FFFF, 32'h0000_0FFF},
   parameter int                        TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     m_valid,
   output logic                     m_ready,
   input  logic [31:0]              m_addr,
   input  logic [31:0]              m_wdata,
   input  logic [3:0]               m_wstrb,
   output logic [31:0]              m_rdata,
   output logic                     m_err,
   output logic [31:0]              err_addr,
   output logic [NUM_SLAVES-1:0]    s_valid,
   input  logic [NUM_SLAVES-1:0]    s_ready,
   output logic [31:0]              s_addr,
   output logic [31:0]              s_wdata,
   output logic [3:0]               s_wstrb,
   input  logic [32*NUM_SLAVES-1:0] s_rdata
);

   localparam int IDX_W = idx_width(NUM_SLAVES);

   bus_state_e            state_r;
   logic [NUM_SLAVES-1:0] sel_r;
   logic [NUM_SLAVES-1:0] dec_sel_s;
   logic                  dec_miss_s;
   logic [IDX_W-1:0]      sel_idx_s;
   logic                  sel_ready_s;
`ifdef BUS_TIMEOUT_EN
   logic [31:0]           cnt_r;
`endif

   mem_bus_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_LAST (SLAVE_LAST)
   ) u_decode (
      .addr (m_addr),
      .sel  (dec_sel_s),
      .miss (dec_miss_s)
   );

   // Binary index of the latched select; sel_r is one-hot so OR-merging is exact.
   always_comb begin
      sel_idx_s = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         sel_idx_s = sel_idx_s | (sel_r[i] ? IDX_W'(i) : IDX_W'(0));
      end
   end

   assign sel_ready_s = |(s_ready & sel_r);
   assign s_valid     = (state_r == ST_ACTIVE) ? sel_r : '0;

   // Transaction sequencer: IDLE accepts and decodes, ACTIVE waits on the slave, DONE pulses m_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         sel_r    <= '0;
         m_ready  <= 1'b0;
         m_err    <= 1'b0;
         m_rdata  <= 32'h0000_0000;
         err_addr <= 32'h0000_0000;
         s_addr   <= 32'h0000_0000;
         s_wdata  <= 32'h0000_0000;
         s_wstrb  <= 4'h0;
`ifdef BUS_TIMEOUT_EN
         cnt_r    <= 32'd0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               m_ready <= 1'b0;
               if (m_valid) begin
                  s_addr  <= m_addr;
                  s_wdata <= m_wdata;
                  s_wstrb <= m_wstrb;
                  if (dec_miss_s) begin
                     // Unmapped: no slave is touched, writes are dropped.
                     sel_r    <= '0;
                     m_ready  <= 1'b1;
                     m_err    <= 1'b1;
                     m_rdata  <= ERR_RDATA;
                     err_addr <= m_addr;
                     state_r  <= ST_DONE;
                  end else begin
                     sel_r   <= dec_sel_s;
                     state_r <= ST_ACTIVE;
`ifdef BUS_TIMEOUT_EN
                     cnt_r   <= 32'd0;
`endif
                  end
               end
            end
            ST_ACTIVE: begin
               if (sel_ready_s) begin
                  m_rdata <= s_rdata[32'd32 * sel_idx_s +: 32];
                  m_err   <= 1'b0;
                  m_ready <= 1'b1;
                  state_r <= ST_DONE;
`ifdef BUS_TIMEOUT_EN
               end else if (cnt_r == 32'(TIMEOUT_CYCLES - 1)) begin
                  m_rdata  <= ERR_RDATA;
                  m_err    <= 1'b1;
                  err_addr <= s_addr;
                  m_ready  <= 1'b1;
                  state_r  <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
`endif
               end
            end
            ST_DONE: begin
               m_ready <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               m_ready <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
